// File: rtl/mult_hilo_unit.sv
// Iterative multiply / multiply-accumulate unit owning the HI/LO pair.
// Retires BITS_PER_CYCLE multiplier bits per cycle; MUL holds the requester until its result is ready.
module mult_hilo_unit #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        ALUOp,
  input  logic        MULOp,
  input  logic [5:0]  Func,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic [31:0] Result,
  output logic        ResultValid,
  output logic        Stall,
  output logic        Busy,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam int unsigned N  = 32 / BITS_PER_CYCLE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ITER, FINISH} stateT;
  typedef enum logic [1:0] {KIND_MULT, KIND_MADD, KIND_MSUB, KIND_MUL} opKindT;

  stateT   state, nextState;
  opKindT  opKind, reqKind;
  logic    reqStart, reqSigned, reqMfhi, reqMflo, reqMthi, reqMtlo, reqAny;
  logic    signFlag;
  logic [63:0] mcand, prod, partial, signedProd;
  logic [31:0] mplier, hiReg, loReg, absA, absB;
  logic [CW-1:0] cnt;

  always_comb begin
    reqStart  = 1'b0;
    reqSigned = 1'b0;
    reqKind   = KIND_MULT;
    reqMfhi   = 1'b0;
    reqMflo   = 1'b0;
    reqMthi   = 1'b0;
    reqMtlo   = 1'b0;
    if (ALUOp) begin
      case (Func)
        6'h18: begin reqStart = 1'b1; reqSigned = 1'b1; end
        6'h19: reqStart = 1'b1;
        6'h10: reqMfhi = 1'b1;
        6'h11: reqMthi = 1'b1;
        6'h12: reqMflo = 1'b1;
        6'h13: reqMtlo = 1'b1;
        default: ;
      endcase
    end else if (MULOp) begin
      case (Func)
        6'h00: begin reqStart = 1'b1; reqSigned = 1'b1; reqKind = KIND_MADD; end
        6'h01: begin reqStart = 1'b1; reqKind = KIND_MADD; end
        6'h02: begin reqStart = 1'b1; reqSigned = 1'b1; reqKind = KIND_MUL; end
        6'h04: begin reqStart = 1'b1; reqSigned = 1'b1; reqKind = KIND_MSUB; end
        6'h05: begin reqStart = 1'b1; reqKind = KIND_MSUB; end
        default: ;
      endcase
    end
  end

  assign reqAny = reqStart | reqMfhi | reqMflo | reqMthi | reqMtlo;

  // 0x80000000 negates to itself, which read as unsigned is the correct magnitude.
  assign absA = (reqSigned && SrcA[31]) ? (32'd0 - SrcA) : SrcA;
  assign absB = (reqSigned && SrcB[31]) ? (32'd0 - SrcB) : SrcB;

  always_comb begin
    partial = '0;
    for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
    end
  end

  assign signedProd = signFlag ? (64'd0 - prod) : prod;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (reqStart) nextState = ITER;
      ITER:    if (cnt == CW'(N - 1)) nextState = FINISH;
      FINISH:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    Result      = '0;
    ResultValid = 1'b0;
    Stall       = 1'b0;
    Busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (reqMfhi) begin
          Result      = hiReg;
          ResultValid = 1'b1;
        end else if (reqMflo) begin
          Result      = loReg;
          ResultValid = 1'b1;
        end
        if (reqStart && reqKind == KIND_MUL) Stall = 1'b1;
      end
      ITER: Stall = reqAny;
      FINISH: begin
        if (opKind == KIND_MUL && reqStart && reqKind == KIND_MUL) begin
          Result      = signedProd[31:0];
          ResultValid = 1'b1;
        end else begin
          Stall = reqAny;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      hiReg    <= '0;
      loReg    <= '0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      cnt      <= '0;
      opKind   <= KIND_MULT;
      signFlag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reqStart) begin
            mcand    <= {32'd0, absA};
            mplier   <= absB;
            prod     <= '0;
            cnt      <= '0;
            opKind   <= reqKind;
            signFlag <= reqSigned & (SrcA[31] ^ SrcB[31]);
          end else begin
            if (reqMthi) hiReg <= SrcA;
            if (reqMtlo) loReg <= SrcA;
          end
        end
        ITER: begin
          prod   <= prod + partial;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          cnt    <= cnt + 1'b1;
        end
        FINISH: begin
          case (opKind)
            KIND_MULT: {hiReg, loReg} <= signedProd;
            KIND_MADD: {hiReg, loReg} <= {hiReg, loReg} + signedProd;
            KIND_MSUB: {hiReg, loReg} <= {hiReg, loReg} - signedProd;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign Hi = hiReg;
  assign Lo = loReg;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Bench for mult_hilo_unit: two instances (1 and 4 bits per cycle) driven in turn,
// checked against a 64-bit arithmetic model of HI/LO.
module tb_mult_hilo_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        nReset;
  logic        aluOp [2];
  logic        mulOp [2];
  logic [5:0]  func  [2];
  logic [31:0] srcA  [2];
  logic [31:0] srcB  [2];
  logic [31:0] result [2];
  logic [31:0] hi [2];
  logic [31:0] lo [2];
  logic        resultValid [2];
  logic        stall [2];
  logic        busy [2];

  int tests  = 0;
  int failed = 0;
  logic [63:0] modelHiLo [2];
  int nIter [2];

  mult_hilo_unit #(.BITS_PER_CYCLE(1)) dut0 (
    .Clock(clock), .nReset(nReset), .ALUOp(aluOp[0]), .MULOp(mulOp[0]), .Func(func[0]),
    .SrcA(srcA[0]), .SrcB(srcB[0]), .Result(result[0]), .ResultValid(resultValid[0]),
    .Stall(stall[0]), .Busy(busy[0]), .Hi(hi[0]), .Lo(lo[0])
  );

  mult_hilo_unit #(.BITS_PER_CYCLE(4)) dut1 (
    .Clock(clock), .nReset(nReset), .ALUOp(aluOp[1]), .MULOp(mulOp[1]), .Func(func[1]),
    .SrcA(srcA[1]), .SrcB(srcB[1]), .Result(result[1]), .ResultValid(resultValid[1]),
    .Stall(stall[1]), .Busy(busy[1]), .Hi(hi[1]), .Lo(lo[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int d, input logic a, input logic m, input logic [5:0] f,
                        input logic [31:0] x, input logic [31:0] y);
    aluOp[d] = a; mulOp[d] = m; func[d] = f; srcA[d] = x; srcB[d] = y;
  endtask

  task automatic clearReq(input int d);
    setReq(d, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0);
  endtask

  task automatic checkHiLo(input int d, input string tag);
    check({tag, "_hi"}, hi[d], modelHiLo[d][63:32]);
    check({tag, "_lo"}, lo[d], modelHiLo[d][31:0]);
  endtask

  // 0 = writes HI/LO, 1 = accumulates, 2 = subtracts, 3 = MUL to GPR
  function automatic int kindOf(input logic alu, input logic [5:0] f);
    if (alu) return 0;
    if (f == 6'h02) return 3;
    if (f == 6'h04 || f == 6'h05) return 2;
    return 1;
  endfunction

  function automatic logic isSignedOp(input logic alu, input logic [5:0] f);
    if (alu) return f == 6'h18;
    return f == 6'h00 || f == 6'h02 || f == 6'h04;
  endfunction

  function automatic logic [63:0] product(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic doMultiply(input int d, input logic alu, input logic [5:0] f,
                            input logic [31:0] a, input logic [31:0] b, input string tag);
    int kind, cnt;
    logic [63:0] p;
    kind = kindOf(alu, f);
    p = product(isSignedOp(alu, f), a, b);
    setReq(d, alu, !alu, f, a, b);
    @(negedge clock);
    cnt = 0;
    if (kind != 3) begin
      check({tag, "_startStall"}, stall[d], 1'b0);
      @(posedge clock); #1;
      clearReq(d);
      @(negedge clock);
      while (busy[d] === 1'b1 && cnt < 200) begin cnt++; @(negedge clock); end
      check({tag, "_busyCycles"}, cnt, nIter[d] + 1);
      if (kind == 0) modelHiLo[d] = p;
      else if (kind == 1) modelHiLo[d] = modelHiLo[d] + p;
      else modelHiLo[d] = modelHiLo[d] - p;
      checkHiLo(d, tag);
      @(posedge clock); #1;
    end else begin
      while (stall[d] === 1'b1 && cnt < 200) begin cnt++; @(negedge clock); end
      check({tag, "_stallCycles"}, cnt, nIter[d] + 1);
      check({tag, "_valid"}, resultValid[d], 1'b1);
      check({tag, "_result"}, result[d], p[31:0]);
      @(posedge clock); #1;
      clearReq(d);
      @(negedge clock);
      check({tag, "_noRestart"}, busy[d], 1'b0);
      check({tag, "_validDrop"}, resultValid[d], 1'b0);
      checkHiLo(d, tag);
      @(posedge clock); #1;
    end
  endtask

  task automatic doMove(input int d, input logic [5:0] f, input logic [31:0] a, input string tag);
    setReq(d, 1'b1, 1'b0, f, a, 32'h0);
    @(negedge clock);
    check({tag, "_stall"}, stall[d], 1'b0);
    if (f == 6'h10 || f == 6'h12) begin
      check({tag, "_valid"}, resultValid[d], 1'b1);
      check({tag, "_result"}, result[d], (f == 6'h10) ? modelHiLo[d][63:32] : modelHiLo[d][31:0]);
    end else begin
      check({tag, "_valid"}, resultValid[d], 1'b0);
      if (f == 6'h11) modelHiLo[d][63:32] = a;
      else modelHiLo[d][31:0] = a;
    end
    @(posedge clock); #1;
    clearReq(d);
    @(negedge clock);
    checkHiLo(d, tag);
    @(posedge clock); #1;
  endtask

  task automatic doMfloWhileBusy(input int d, input logic [31:0] a, input logic [31:0] b);
    int cnt;
    setReq(d, 1'b1, 1'b0, 6'h18, a, b);
    @(posedge clock); #1;
    setReq(d, 1'b1, 1'b0, 6'h12, 32'h0, 32'h0);
    modelHiLo[d] = product(1'b1, a, b);
    cnt = 0;
    @(negedge clock);
    while (stall[d] === 1'b1 && cnt < 200) begin cnt++; @(negedge clock); end
    check("mfloHeld_stallCycles", cnt, nIter[d] + 1);
    check("mfloHeld_busy", busy[d], 1'b0);
    check("mfloHeld_valid", resultValid[d], 1'b1);
    check("mfloHeld_result", result[d], modelHiLo[d][31:0]);
    @(posedge clock); #1;
    clearReq(d);
  endtask

  task automatic doNoRequest(input int d, input logic a, input logic m, input logic [5:0] f, input string tag);
    setReq(d, a, m, f, 32'hDEADBEEF, 32'h12345678);
    @(negedge clock);
    check({tag, "_stall"}, stall[d], 1'b0);
    check({tag, "_valid"}, resultValid[d], 1'b0);
    @(posedge clock); #1;
    clearReq(d);
    @(negedge clock);
    check({tag, "_busy"}, busy[d], 1'b0);
    checkHiLo(d, tag);
    @(posedge clock); #1;
  endtask

  task automatic doResetMidOp(input int d, input int k);
    setReq(d, 1'b1, 1'b0, 6'h19, 32'h12345678, 32'h9ABCDEF0);
    @(posedge clock); #1;
    clearReq(d);
    repeat (k) @(negedge clock);
    check("resetMid_busyBefore", busy[d], 1'b1);
    nReset = 1'b0;
    #1;
    modelHiLo[0] = '0;
    modelHiLo[1] = '0;
    check("resetMid_busy", busy[d], 1'b0);
    checkHiLo(d, "resetMid");
    @(negedge clock);
    nReset = 1'b1;
    @(posedge clock); #1;
  endtask

  function automatic logic [31:0] pickOperand();
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    logic       opAlu [11];
    logic [5:0] opFunc [11];
    int         sel;
    logic [31:0] ra, rb;
    opAlu  = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    opFunc = '{6'h18, 6'h19, 6'h00, 6'h01, 6'h02, 6'h04, 6'h05, 6'h10, 6'h11, 6'h12, 6'h13};
    nIter[0] = 32;
    nIter[1] = 8;
    nReset = 1'b0;
    clearReq(0);
    clearReq(1);
    modelHiLo[0] = '0;
    modelHiLo[1] = '0;
    #12;
    for (int d = 0; d < 2; d++) begin
      check("reset_busy", busy[d], 1'b0);
      check("reset_stall", stall[d], 1'b0);
      check("reset_valid", resultValid[d], 1'b0);
      check("reset_result", result[d], 32'h0);
      checkHiLo(d, "reset");
    end
    @(negedge clock);
    nReset = 1'b1;
    @(posedge clock); #1;

    for (int d = 0; d < 2; d++) begin
      doMultiply(d, 1'b1, 6'h18, 32'hFFFFFFFF, 32'd2, "mult");
      check("mult_const", {hi[d], lo[d]}, 64'hFFFFFFFF_FFFFFFFE);
      doMultiply(d, 1'b1, 6'h19, 32'hFFFFFFFF, 32'd2, "multu");
      check("multu_const", {hi[d], lo[d]}, 64'h00000001_FFFFFFFE);
      doMove(d, 6'h11, 32'd0, "mthi");
      doMove(d, 6'h13, 32'd10, "mtlo");
      doMultiply(d, 1'b0, 6'h00, 32'd3, 32'd4, "madd");
      check("madd_const", {hi[d], lo[d]}, 64'd22);
      doMultiply(d, 1'b0, 6'h05, 32'd1, 32'd23, "msubu");
      check("msubu_const", {hi[d], lo[d]}, 64'hFFFFFFFF_FFFFFFFF);
      doMove(d, 6'h10, 32'd0, "mfhi");
      doMfloWhileBusy(d, 32'hFFFF1234, 32'h00005678);
      doMultiply(d, 1'b0, 6'h02, 32'd7, 32'hFFFFFFFD, "mul");
      doNoRequest(d, 1'b1, 1'b0, 6'h3F, "badAlu");
      doNoRequest(d, 1'b0, 1'b1, 6'h03, "badMul");
      doNoRequest(d, 1'b0, 1'b0, 6'h18, "noQual");
      doResetMidOp(d, (nIter[d] > 20) ? 10 : nIter[d] / 2);
      doMultiply(d, 1'b1, 6'h18, 32'h80000000, 32'h80000000, "multMin");
      check("multMin_const", {hi[d], lo[d]}, 64'h40000000_00000000);
      doMultiply(d, 1'b0, 6'h04, 32'h80000000, 32'h00000003, "msubMin");
      for (int i = 0; i < 20; i++) begin
        sel = $urandom_range(0, 10);
        ra = pickOperand();
        rb = pickOperand();
        if (opFunc[sel] inside {6'h10, 6'h11, 6'h12, 6'h13} && opAlu[sel])
          doMove(d, opFunc[sel], ra, "rndMove");
        else
          doMultiply(d, opAlu[sel], opFunc[sel], ra, rb, "rndMul");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
